// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 fetch/decode/execute slice:
// instruction codes, register ids, ALU functions, condition codes and
// the condition-evaluation helper.
package y86_pkg;

   // Instruction codes (high nibble of byte 0)
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] I_IADDQ  = 4'hC;

   // Register ids
   localparam logic [3:0] RSP   = 4'h4;
   localparam logic [3:0] RNONE = 4'hF;

   // OPq function codes
   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   // jXX / cmovXX condition function codes
   localparam logic [3:0] C_ALWAYS = 4'h0;
   localparam logic [3:0] C_LE     = 4'h1;
   localparam logic [3:0] C_L      = 4'h2;
   localparam logic [3:0] C_E      = 4'h3;
   localparam logic [3:0] C_NE     = 4'h4;
   localparam logic [3:0] C_GE     = 4'h5;
   localparam logic [3:0] C_G      = 4'h6;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

   localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

   // Evaluate a branch/move condition against the condition codes
   function automatic logic cond_eval(input logic [3:0] fn, input cc_t cc);
      logic lt;
      logic res;
      lt = cc.sf ^ cc.of;
      case (fn)
         C_ALWAYS: res = 1'b1;
         C_LE:     res = lt | cc.zf;
         C_L:      res = lt;
         C_E:      res = cc.zf;
         C_NE:     res = ~cc.zf;
         C_GE:     res = ~lt;
         C_G:      res = ~lt & ~cc.zf;
         default:  res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: 15 x XLEN registers (ids 0..14), id F reads as
// zero and is never written. Two asynchronous read ports, two write
// ports (E and M); when both target the same register the M port wins.
module y86_regfile
   import y86_pkg::*;
#(
   parameter int XLEN = 64
)(
   input  logic            clock,
   input  logic            reset,
   input  logic [3:0]      src_a,
   input  logic [3:0]      src_b,
   input  logic [3:0]      dst_e,
   input  logic [3:0]      dst_m,
   input  logic [XLEN-1:0] val_e,
   input  logic [XLEN-1:0] val_m,
   output logic [XLEN-1:0] val_a,
   output logic [XLEN-1:0] val_b
);

   logic [XLEN-1:0] regs [0:14];

   assign val_a = (src_a == RNONE) ? '0 : regs[src_a];
   assign val_b = (src_b == RNONE) ? '0 : regs[src_b];

   // Register write-back; reset clears every register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: the array is reset element by element, so it must map to flops; a RAM macro cannot be cleared like this.
         for (int i = 0; i < 15; i++) begin
            regs[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking writes; the later M assignment overrides E on the same register, giving valM priority.
         if (dst_e != RNONE) regs[dst_e] <= val_e;
         if (dst_m != RNONE) regs[dst_m] <= val_m;
      end
   end

endmodule

// File: rtl/y86_fetch_decode_exec.sv
// Y86-64 SEQ front half: fetch from a byte-packed image, decode, register
// read/write-back and execute (ALU + condition codes).
// Optional feature: define Y86_IADDQ_EN to make icode C (iaddq V,rB) legal.
module y86_fetch_decode_exec
   import y86_pkg::*;
#(
   parameter int IMEM_BYTES = 80,
   parameter int XLEN       = 64
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic [0:IMEM_BYTES*8-1] instmem,
   input  logic [63:0]             pc,
   input  logic [XLEN-1:0]         valM,
   output logic [3:0]              icode,
   output logic [3:0]              ifun,
   output logic [3:0]              rA,
   output logic [3:0]              rB,
   output logic [XLEN-1:0]         valC,
   output logic [63:0]             valP,
   output logic [XLEN-1:0]         valA,
   output logic [XLEN-1:0]         valB,
   output logic [XLEN-1:0]         valE,
   output logic                    cnd,
   output logic                    halt,
   output logic                    instr_valid,
   output logic                    imem_error
);

   localparam int IDX_W = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

   logic [7:0]      mem_bytes [0:IMEM_BYTES-1];
   logic [7:0]      ibytes [0:9];
   logic            legal, need_reg, need_valc;
   logic [3:0]      ilen;
   logic [64:0]     end_addr;
   logic            ok;
   logic            cond_raw;
   logic [3:0]      src_a, src_b, dst_e, dst_m;
   logic [XLEN-1:0] alu_out;
   logic            alu_of;
   logic            cc_we;
   cc_t             cc;

   // Split the packed image into bytes; byte k occupies instmem[8k +: 8]
   always_comb begin
      for (int k = 0; k < IMEM_BYTES; k++) begin
         mem_bytes[k] = instmem[8*k +: 8];
      end
   end

   // Fetch ten bytes at pc; addresses past the end of the image read as zero
   always_comb begin
      logic [64:0] addr;
      for (int i = 0; i < 10; i++) begin
         // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
         ibytes[i] = 8'h00;
         addr = {1'b0, pc} + 65'(i);
         if (addr < 65'(IMEM_BYTES)) ibytes[i] = mem_bytes[addr[IDX_W-1:0]];
      end
   end

   assign icode = ibytes[0][7:4];
   assign ifun  = ibytes[0][3:0];

   // Classify the icode: legality, register byte, constant word
   always_comb begin
      legal     = 1'b0;
      need_reg  = 1'b0;
      need_valc = 1'b0;
      case (icode)
         I_HALT, I_NOP, I_RET: legal = 1'b1;
         I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
            legal    = 1'b1;
            need_reg = 1'b1;
         end
         I_JXX, I_CALL: begin
            legal     = 1'b1;
            need_valc = 1'b1;
         end
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
            legal     = 1'b1;
            need_reg  = 1'b1;
            need_valc = 1'b1;
         end
`ifdef Y86_IADDQ_EN
         I_IADDQ: begin
            legal     = 1'b1;
            need_reg  = 1'b1;
            need_valc = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign ilen        = 4'd1 + {3'b000, need_reg} + {need_valc, 3'b000};
   assign valP        = pc + 64'(ilen);
   assign end_addr    = {1'b0, pc} + 65'(ilen);
   assign imem_error  = end_addr > 65'(IMEM_BYTES);
   assign instr_valid = legal;
   assign halt        = (icode == I_HALT);
   assign ok          = legal & ~imem_error & ~halt;

   assign rA = need_reg ? ibytes[1][7:4] : RNONE;
   assign rB = need_reg ? ibytes[1][3:0] : RNONE;

   // Assemble the little-endian constant: bytes 1..8 for jXX/call, 2..9 otherwise
   always_comb begin
      valC = '0;
      if (icode == I_JXX || icode == I_CALL) begin
         for (int i = 0; i < 8; i++) valC[8*i +: 8] = ibytes[1+i];
      end else if (need_valc) begin
         for (int i = 0; i < 8; i++) valC[8*i +: 8] = ibytes[2+i];
      end
   end

   // Conditions only matter for jXX and cmovXX, and never for a suppressed instruction
   assign cond_raw = cond_eval(ifun, cc);
   assign cnd      = ok & (icode == I_JXX || icode == I_RRMOVQ) & cond_raw;

   // Register sources and destinations; destinations are dropped when the instruction must not commit
   always_comb begin
      src_a = RNONE;
      src_b = RNONE;
      dst_e = RNONE;
      dst_m = RNONE;
      case (icode)
         I_RRMOVQ: begin
            src_a = rA;
            dst_e = cnd ? rB : RNONE;
         end
         I_IRMOVQ: dst_e = rB;
         I_RMMOVQ: begin
            src_a = rA;
            src_b = rB;
         end
         I_MRMOVQ: begin
            src_b = rB;
            dst_m = rA;
         end
         I_OPQ: begin
            src_a = rA;
            src_b = rB;
            dst_e = rB;
         end
         I_CALL: begin
            src_b = RSP;
            dst_e = RSP;
         end
         I_RET: begin
            src_a = RSP;
            src_b = RSP;
            dst_e = RSP;
         end
         I_PUSHQ: begin
            src_a = rA;
            src_b = RSP;
            dst_e = RSP;
         end
         I_POPQ: begin
            src_a = RSP;
            src_b = RSP;
            dst_e = RSP;
            dst_m = rA;
         end
`ifdef Y86_IADDQ_EN
         I_IADDQ: begin
            src_b = rB;
            dst_e = rB;
         end
`endif
         default: ;
      endcase
      if (!ok) begin
         dst_e = RNONE;
         dst_m = RNONE;
      end
   end

   y86_regfile #(.XLEN(XLEN)) u_regfile (
      .clock (clock),
      .reset (reset),
      .src_a (src_a),
      .src_b (src_b),
      .dst_e (dst_e),
      .dst_m (dst_m),
      .val_e (valE),
      .val_m (valM),
      .val_a (valA),
      .val_b (valB)
   );

   // ALU: compute valE and the overflow flag for the current instruction
   always_comb begin
      alu_out = '0;
      alu_of  = 1'b0;
      cc_we   = 1'b0;
      case (icode)
         I_RRMOVQ:           alu_out = valA;
         I_IRMOVQ:           alu_out = valC;
         I_RMMOVQ, I_MRMOVQ: alu_out = valB + valC;
         I_CALL, I_PUSHQ:    alu_out = valB - XLEN'(8);
         I_RET, I_POPQ:      alu_out = valB + XLEN'(8);
         I_OPQ: begin
            cc_we = 1'b1;
            case (ifun)
               ALU_ADD: begin
                  alu_out = valB + valA;
                  alu_of  = (valA[XLEN-1] == valB[XLEN-1]) && (alu_out[XLEN-1] != valA[XLEN-1]);
               end
               ALU_SUB: begin
                  alu_out = valB - valA;
                  alu_of  = (valA[XLEN-1] != valB[XLEN-1]) && (alu_out[XLEN-1] != valB[XLEN-1]);
               end
               ALU_AND: alu_out = valB & valA;
               ALU_XOR: alu_out = valB ^ valA;
               default: ;
            endcase
         end
`ifdef Y86_IADDQ_EN
         I_IADDQ: begin
            cc_we   = 1'b1;
            alu_out = valB + valC;
            alu_of  = (valC[XLEN-1] == valB[XLEN-1]) && (alu_out[XLEN-1] != valC[XLEN-1]);
         end
`endif
         default: ;
      endcase
   end

   assign valE = ok ? alu_out : '0;

   // Condition-code register: set to ZF=1 on reset, updated by arithmetic instructions that commit
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cc <= CC_RESET;
      end else if (ok && cc_we) begin
         cc <= '{zf: (alu_out == '0), sf: alu_out[XLEN-1], of: alu_of};
      end
   end

endmodule

// File: tb/tb_y86_fetch_decode_exec.sv
// Self-checking bench for y86_fetch_decode_exec: a table of program steps
// over one instruction image, then hand-written overflow and reset sequences.
module tb_y86_fetch_decode_exec;

   localparam int IMEM_BYTES = 80;

   logic                    clock = 1'b0;
   logic                    reset;
   logic [0:IMEM_BYTES*8-1] instmem;
   logic [63:0]             pc, valM;
   logic [3:0]              icode, ifun, rA, rB;
   logic [63:0]             valC, valP, valA, valB, valE;
   logic                    cnd, halt, instr_valid, imem_error;

   int passed = 0;
   int total  = 0;

   y86_fetch_decode_exec #(.IMEM_BYTES(IMEM_BYTES), .XLEN(64)) dut (
      .clock       (clock),
      .reset       (reset),
      .instmem     (instmem),
      .pc          (pc),
      .valM        (valM),
      .icode       (icode),
      .ifun        (ifun),
      .rA          (rA),
      .rB          (rB),
      .valC        (valC),
      .valP        (valP),
      .valA        (valA),
      .valB        (valB),
      .valE        (valE),
      .cnd         (cnd),
      .halt        (halt),
      .instr_valid (instr_valid),
      .imem_error  (imem_error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] valm;
      logic [3:0]  icode;
      logic [3:0]  rb;
      logic [63:0] valc;
      logic [63:0] valp;
      logic [63:0] vala;
      logic [63:0] vale;
      logic        cnd;
      logic        valid;
      logic        err;
      logic        hlt;
   } vec_t;

   localparam int NVEC = 21;
   vec_t vecs [NVEC];

`ifdef Y86_IADDQ_EN
   localparam logic [63:0] R2_LATE = 64'd15;
   localparam logic        JG_LATE = 1'b1;
`else
   localparam logic [63:0] R2_LATE = 64'd10;
   localparam logic        JG_LATE = 1'b0;
`endif

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual === expected) passed++;
      else $display("FAIL %s: got %h expected %h", name, actual, expected);
   endtask

   task automatic put1(input int a, input logic [7:0] b0);
      instmem[8*a +: 8] = b0;
   endtask

   task automatic put2(input int a, input logic [7:0] b0, input logic [7:0] b1);
      put1(a, b0);
      put1(a + 1, b1);
   endtask

   // opcode byte, register byte, 8-byte little-endian constant
   task automatic put_irmov(input int a, input logic [7:0] b0, input logic [7:0] b1, input logic [63:0] v);
      put2(a, b0, b1);
      for (int i = 0; i < 8; i++) put1(a + 2 + i, v[8*i +: 8]);
   endtask

   // opcode byte, 8-byte little-endian destination
   task automatic put_jump(input int a, input logic [7:0] b0, input logic [63:0] v);
      put1(a, b0);
      for (int i = 0; i < 8; i++) put1(a + 1 + i, v[8*i +: 8]);
   endtask

   task automatic step(input logic [63:0] p, input logic [63:0] m);
      @(negedge clock);
      pc   = p;
      valM = m;
      #1;
   endtask

   initial begin
      reset   = 1'b1;
      pc      = 64'd70;
      valM    = '0;
      instmem = '0;

      put_irmov(0,  8'h30, 8'hF2, 64'd10);      // irmovq $10,%rdx
      put_irmov(10, 8'h30, 8'hF3, 64'd3);       // irmovq $3,%rbx
      put2(20, 8'h61, 8'h23);                   // subq %rdx,%rbx
      put_jump(22, 8'h72, 64'h40);              // jl 0x40
      put_irmov(31, 8'h30, 8'hF4, 64'h100);     // irmovq $0x100,%rsp
      put2(41, 8'hA0, 8'h2F);                   // pushq %rdx
      put2(43, 8'hB0, 8'h4F);                   // popq %rsp
      put2(45, 8'h20, 8'h40);                   // rrmovq %rsp,%rax
      put1(47, 8'hD0);                          // illegal
      put_irmov(48, 8'hC0, 8'hF2, 64'd5);       // iaddq $5,%rdx
      put_jump(58, 8'h76, 64'h0);               // jg 0
      put2(67, 8'h60, 8'h76);                   // addq %rdi,%rsi
      put1(69, 8'h10);                          // nop
      put1(70, 8'h00);                          // halt
      put2(71, 8'h22, 8'h23);                   // cmovl %rdx,%rbx
      put2(76, 8'h30, 8'hF2);                   // irmovq truncated by image end

      //               pc     valM    icode  rb     valc      valp     vala      vale                    cnd   valid err   hlt
      vecs[0]  = '{64'd22, 64'd0,    4'h7, 4'hF, 64'h40,  64'd31, 64'd0,    64'd0,                  1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{64'd45, 64'd0,    4'h2, 4'h0, 64'd0,   64'd47, 64'd0,    64'd0,                  1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{64'd0,  64'd0,    4'h3, 4'h2, 64'd10,  64'd10, 64'd0,    64'd10,                 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{64'd10, 64'd0,    4'h3, 4'h3, 64'd3,   64'd20, 64'd0,    64'd3,                  1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{64'd20, 64'd0,    4'h6, 4'h3, 64'd0,   64'd22, 64'd10,   64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{64'd22, 64'd0,    4'h7, 4'hF, 64'h40,  64'd31, 64'd0,    64'd0,                  1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{64'd71, 64'd0,    4'h2, 4'h3, 64'd0,   64'd73, 64'd10,   64'd10,                 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{64'd20, 64'd0,    4'h6, 4'h3, 64'd0,   64'd22, 64'd10,   64'd0,                  1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{64'd22, 64'd0,    4'h7, 4'hF, 64'h40,  64'd31, 64'd0,    64'd0,                  1'b0, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{64'd31, 64'd0,    4'h3, 4'h4, 64'h100, 64'd41, 64'd0,    64'h100,                1'b0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{64'd41, 64'd0,    4'hA, 4'hF, 64'd0,   64'd43, 64'd10,   64'hF8,                 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{64'd43, 64'h55,   4'hB, 4'hF, 64'd0,   64'd45, 64'hF8,   64'h100,                1'b0, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{64'd45, 64'd0,    4'h2, 4'h0, 64'd0,   64'd47, 64'h55,   64'h55,                 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{64'd47, 64'd0,    4'hD, 4'hF, 64'd0,   64'd48, 64'd0,    64'd0,                  1'b0, 1'b0, 1'b0, 1'b0};
`ifdef Y86_IADDQ_EN
      vecs[14] = '{64'd48, 64'd0,    4'hC, 4'h2, 64'd5,   64'd58, 64'd0,    64'd15,                 1'b0, 1'b1, 1'b0, 1'b0};
`else
      vecs[14] = '{64'd48, 64'd0,    4'hC, 4'hF, 64'd0,   64'd49, 64'd0,    64'd0,                  1'b0, 1'b0, 1'b0, 1'b0};
`endif
      vecs[15] = '{64'd41, 64'd0,    4'hA, 4'hF, 64'd0,   64'd43, R2_LATE,  64'h4D,                 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[16] = '{64'd58, 64'd0,    4'h7, 4'hF, 64'd0,   64'd67, 64'd0,    64'd0,                  JG_LATE, 1'b1, 1'b0, 1'b0};
      vecs[17] = '{64'd76, 64'd0,    4'h3, 4'h2, 64'd0,   64'd86, 64'd0,    64'd0,                  1'b0, 1'b1, 1'b1, 1'b0};
      vecs[18] = '{64'd41, 64'd0,    4'hA, 4'hF, 64'd0,   64'd43, R2_LATE,  64'h45,                 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[19] = '{64'd70, 64'd0,    4'h0, 4'hF, 64'd0,   64'd71, 64'd0,    64'd0,                  1'b0, 1'b1, 1'b0, 1'b1};
      vecs[20] = '{64'd69, 64'd0,    4'h1, 4'hF, 64'd0,   64'd70, 64'd0,    64'd0,                  1'b0, 1'b1, 1'b0, 1'b0};

      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Table-driven program trace; each step commits at the following rising edge
      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].pc, vecs[i].valm);
         check($sformatf("v%0d.icode", i), 64'(icode), 64'(vecs[i].icode));
         check($sformatf("v%0d.rB", i), 64'(rB), 64'(vecs[i].rb));
         check($sformatf("v%0d.valC", i), valC, vecs[i].valc);
         check($sformatf("v%0d.valP", i), valP, vecs[i].valp);
         check($sformatf("v%0d.valA", i), valA, vecs[i].vala);
         check($sformatf("v%0d.valE", i), valE, vecs[i].vale);
         check($sformatf("v%0d.instr_valid", i), 64'(instr_valid), 64'(vecs[i].valid));
         check($sformatf("v%0d.imem_error", i), 64'(imem_error), 64'(vecs[i].err));
         check($sformatf("v%0d.halt", i), 64'(halt), 64'(vecs[i].hlt));
         if (vecs[i].icode == 4'h2 || vecs[i].icode == 4'h7 || !vecs[i].valid || vecs[i].err || vecs[i].hlt)
            check($sformatf("v%0d.cnd", i), 64'(cnd), 64'(vecs[i].cnd));
      end

      // Signed overflow on addq: 0x7FFF...F + 1
      put_irmov(0,  8'h30, 8'hF6, 64'h7FFF_FFFF_FFFF_FFFF);   // irmovq max,%rsi
      put_irmov(10, 8'h30, 8'hF7, 64'd1);                     // irmovq $1,%rdi
      step(64'd0, 64'd0);
      check("ovf.irmov_max.valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
      step(64'd10, 64'd0);
      check("ovf.irmov_one.valE", valE, 64'd1);
      step(64'd67, 64'd0);
      check("ovf.addq.valA", valA, 64'd1);
      check("ovf.addq.valE", valE, 64'h8000_0000_0000_0000);
      step(64'd22, 64'd0);
      check("ovf.jl_after.cnd", 64'(cnd), 64'd0);
      pc = 64'd69;

      // mrmovq 8(%rsi),%rax: address wraps into the sign bit region
      put_irmov(20, 8'h50, 8'h06, 64'd8);
      step(64'd20, 64'h1234);
      check("mrmov.valE", valE, 64'h8000_0000_0000_0008);
      check("mrmov.valP", valP, 64'd30);
      pc = 64'd69;

      // Reset asserted mid-program clears state at once and blocks writes on an edge
      put_jump(0, 8'h71, 64'd0);                               // jle 0
      step(64'd0, 64'd0);
      check("rst.jle_before.cnd", 64'(cnd), 64'd0);
      @(negedge clock);
      pc = 64'd41;
      #2;
      reset = 1'b1;
      #1;
      check("rst.push.valA", valA, 64'd0);
      check("rst.push.valE", valE, 64'hFFFF_FFFF_FFFF_FFF8);
      pc = 64'd0;
      #1;
      check("rst.jle_during.cnd", 64'(cnd), 64'd1);
      pc = 64'd10;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      pc    = 64'd67;
      #1;
      check("rst.addq_after.valA", valA, 64'd0);
      check("rst.addq_after.valE", valE, 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
